// File: rtl/width_pkg.sv
// Shared types and helpers for the wide-to-narrow unpacker.
//   IN_W_DEF / OUT_W_DEF : default word and slice widths
//   slice_t / word_t     : slice and word payload types at the default widths
//   slice_state_e        : per-word slice FSM states
//   slice_idx()          : maps the slice counter to a bit-slice index
package width_pkg;

  localparam int unsigned IN_W_DEF  = 16;
  localparam int unsigned OUT_W_DEF = 8;

  typedef logic [OUT_W_DEF-1:0] slice_t;
  typedef logic [IN_W_DEF-1:0]  word_t;

  typedef enum logic {
    ST_MID  = 1'b0,
    ST_LAST = 1'b1
  } slice_state_e;

  // Slice k of the head word to present for counter value sel.
  function automatic int unsigned slice_idx(input int unsigned sel,
                                            input int unsigned ratio,
                                            input logic        msb_first);
    return msb_first ? (ratio - 1 - sel) : sel;
  endfunction

endpackage

// File: rtl/width_narrow_unpack_if.sv
// Bus bundle for width_narrow_unpack.
//   master : producer of words / consumer of slices (the environment)
//   slave  : the unpacker itself
//   in_valid/in_ready/in_data            : wide word input
//   out_valid/out_ready/out_data         : narrow slice output
//   out_last/out_flag/level/dup_err      : slice sideband and status
interface width_narrow_unpack_if #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned DEPTH = 4
) ();

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_last;
  logic             out_flag;
  logic [LVL_W-1:0] level;
  logic             dup_err;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_flag, level, dup_err
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, out_flag, level, dup_err
  );

endinterface

// File: rtl/width_word_fifo.sv
// Word store for the unpacker: DEPTH x W registers with wrap-bit pointers.
//   clk, rst_n   : clock, async active-low reset
//   push, wdata  : write wdata at the tail (ignored when full)
//   pop          : drop the head entry (ignored when empty)
//   rdata_c      : head entry
//   full_c, empty_c, level_c : occupancy status
module width_word_fifo #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata_c,
  output logic                       full_c,
  output logic                       empty_c,
  output logic [$clog2(DEPTH):0]     level_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [W-1:0]  mem_q [DEPTH];
  logic          push_ok;
  logic          pop_ok;

  // Same index with differing wrap bits means every entry is occupied.
  assign full_c  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty_c = (wr_ptr_q == rd_ptr_q);
  assign level_c = wr_ptr_q - rd_ptr_q;
  assign rdata_c = mem_q[rd_ptr_q[AW-1:0]];

  assign push_ok = push && !full_c;
  assign pop_ok  = pop && !empty_c;

  // Pointer update; DEPTH is a power of two so full-width increment wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Storage array, no reset needed: entries are only read once written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/width_narrow_unpack.sv
// Wide-to-narrow unpacker: buffers IN_W words and emits them as OUT_W slices
// with an MSB flag and a last-slice marker.
//   clk, rst_n : clock, async active-low reset
//   bus        : width_narrow_unpack_if.slave (word input, slice output, status)
// Optional build macro WIDTH_NARROW_DUP_CHECK_EN: words whose slices are all
// identical are emitted as a single slice; others pulse dup_err after push.
module width_narrow_unpack
  import width_pkg::*;
#(
  parameter int unsigned IN_W      = IN_W_DEF,
  parameter int unsigned OUT_W     = OUT_W_DEF,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  width_narrow_unpack_if.slave  bus
);

  localparam int unsigned RATIO = IN_W / OUT_W;
  localparam int unsigned SEL_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
`ifdef WIDTH_NARROW_DUP_CHECK_EN
  localparam int unsigned DW    = IN_W + 1;
`else
  localparam int unsigned DW    = IN_W;
`endif

  logic [DW-1:0]    wdata;
  logic [DW-1:0]    rdata_c;
  logic             full_c;
  logic             empty_c;
  logic [LVL_W-1:0] level_c;
  logic             push;
  logic             pop;
  logic             advance;
  logic             head_dup;
  logic [IN_W-1:0]  head_word;
  logic [OUT_W-1:0] slices [RATIO];
  logic [SEL_W-1:0] k_idx;

  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] sel_d;
  slice_state_e     state_q;
  slice_state_e     state_d;

  logic             out_valid_c;
  logic             out_last_c;

  assign push = bus.in_valid && !full_c;

`ifdef WIDTH_NARROW_DUP_CHECK_EN
  logic in_all_eq;
  logic dup_err_q;

  // A word counts as a duplicate when every slice equals the lowest one.
  always_comb begin
    in_all_eq = 1'b1;
    for (int unsigned i = 1; i < RATIO; i++) begin
      if (bus.in_data[i*OUT_W +: OUT_W] != bus.in_data[OUT_W-1:0]) in_all_eq = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dup_err_q <= 1'b0;
    else        dup_err_q <= push && !in_all_eq;
  end

  assign wdata       = {in_all_eq, bus.in_data};
  assign head_dup    = rdata_c[IN_W];
  assign bus.dup_err = dup_err_q;
`else
  assign wdata       = bus.in_data;
  assign head_dup    = 1'b0;
  assign bus.dup_err = 1'b0;
`endif

  width_word_fifo #(
    .W     (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wdata   (wdata),
    .pop     (pop),
    .rdata_c (rdata_c),
    .full_c  (full_c),
    .empty_c (empty_c),
    .level_c (level_c)
  );

  assign head_word = rdata_c[IN_W-1:0];

  for (genvar i = 0; i < RATIO; i++) begin : g_slice
    assign slices[i] = head_word[i*OUT_W +: OUT_W];
  end

  assign k_idx = SEL_W'(slice_idx(32'(sel_q), RATIO, MSB_FIRST != 0));

  // Slice FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= '0;
      state_q <= (RATIO == 1) ? ST_LAST : ST_MID;
    end else begin
      sel_q   <= sel_d;
      state_q <= state_d;
    end
  end

  // Slice FSM next state: step through slices, restart on the last one.
  always_comb begin
    sel_d   = sel_q;
    state_d = state_q;
    if (pop) begin
      sel_d   = '0;
      state_d = (RATIO == 1) ? ST_LAST : ST_MID;
    end else if (advance) begin
      sel_d   = sel_q + SEL_W'(1);
      state_d = (sel_d == SEL_W'(RATIO - 1)) ? ST_LAST : ST_MID;
    end
  end

  // Slice FSM outputs and handshake decode.
  always_comb begin
    out_valid_c = !empty_c;
    out_last_c  = out_valid_c && ((state_q == ST_LAST) || head_dup);
    pop         = out_valid_c && bus.out_ready && out_last_c;
    advance     = out_valid_c && bus.out_ready && !out_last_c;
  end

  assign bus.in_ready  = !full_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_last  = out_last_c;
  assign bus.out_data  = slices[k_idx];
  assign bus.out_flag  = slices[k_idx][OUT_W-1];
  assign bus.level     = level_c;

endmodule
